mips_run_ctrl: RTL and testbench

- Run/debug controller that sequences mips_top through three phases: core reset, free-run, and halt.
- Drives the core's reset and a clock-enable. Halts on PC breakpoint, external halt request or cycle budget; supports single-step from halt.
- Sits between the SoC debug/control registers and the core. Gives the hardware equivalent of "run N cycles or until PC==X".

---
 rtl/mips_run_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_mips_run_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_run_ctrl.sv
//==============================================================================
// Module      : mips_run_ctrl
// Description : Run/debug sequencer for mips_top. Holds the core in reset
//               for RST_CYCLES cycles after start, then free-runs it until a
//               PC breakpoint, an external halt request or a cycle budget
//               stops it. Single-step and resume are available from HALTED.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports
//   clk             system clock
//   rst             synchronous active-low reset
//   start_i         pulse: begin / restart a run (ignored while running)
//   step_i          pulse: execute one core cycle while halted
//   halt_req_i      level: request halt; its falling edge resumes from HALTED
//   bp_en_i         breakpoint enable
//   bp_addr_i       breakpoint PC
//   cycle_limit_i   run budget in core cycles, 0 = unlimited
//   pc_current_i    current PC reported by the core
//   core_rst_o      active-high reset to the core
//   core_ce_o       clock enable to the core (combinational)
//   state_o         IDLE=0 RST_HOLD=1 RUN=2 STEP=3 HALTED=4 DONE=5
//   cycle_count_o   core cycles executed since leaving RST_HOLD (saturating)
//   bp_hit_o        sticky: last halt caused by breakpoint
//   timeout_o       sticky: run ended by cycle budget
//   done_o          high in DONE
//==============================================================================
`default_nettype none

module mips_run_ctrl #(
  parameter int RST_CYCLES = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             step_i,
  input  logic             halt_req_i,
  input  logic             bp_en_i,
  input  logic [31:0]      bp_addr_i,
  input  logic [CNT_W-1:0] cycle_limit_i,
  input  logic [31:0]      pc_current_i,
  output logic             core_rst_o,
  output logic             core_ce_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] cycle_count_o,
  output logic             bp_hit_o,
  output logic             timeout_o,
  output logic             done_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RST_HOLD = 3'd1,
    S_RUN      = 3'd2,
    S_STEP     = 3'd3,
    S_HALTED   = 3'd4,
    S_DONE     = 3'd5
  } state_e;

  localparam int            RC_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0] RST_LAST = RC_W'(RST_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic             bp_hit_q, bp_hit_d;
  logic             timeout_q, timeout_d;
  logic             skip_bp_q, skip_bp_d;
  logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic             halt_req_q;

  logic             bp_match;
  logic             limit_hit;
  logic             stop_now;
  logic             halt_fall;
  logic [CNT_W-1:0] cnt_inc;

  // skip_bp masks the breakpoint for one RUN cycle after a step or resume so
  // that the core can move off the breakpoint address.
  assign bp_match  = bp_en_i && (pc_current_i == bp_addr_i) && !skip_bp_q;
  assign limit_hit = (cycle_limit_i != '0) && (cycle_count_q >= cycle_limit_i);
  assign stop_now  = bp_match || halt_req_i || limit_hit;
  assign halt_fall = halt_req_q && !halt_req_i;
  assign cnt_inc   = (&cycle_count_q) ? cycle_count_q : cycle_count_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      cycle_count_q <= '0;
      bp_hit_q      <= 1'b0;
      timeout_q     <= 1'b0;
      skip_bp_q     <= 1'b0;
      rst_cnt_q     <= '0;
      halt_req_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cycle_count_q <= cycle_count_d;
      bp_hit_q      <= bp_hit_d;
      timeout_q     <= timeout_d;
      skip_bp_q     <= skip_bp_d;
      rst_cnt_q     <= rst_cnt_d;
      halt_req_q    <= halt_req_i;
    end
  end

  always_comb begin
    state_d       = state_q;
    cycle_count_d = cycle_count_q;
    bp_hit_d      = bp_hit_q;
    timeout_d     = timeout_q;
    skip_bp_d     = skip_bp_q;
    rst_cnt_d     = rst_cnt_q;
    core_rst_o    = 1'b0;
    core_ce_o     = 1'b0;
    done_o        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        core_rst_o = 1'b1;
        if (start_i) begin
          state_d   = S_RST_HOLD;
          rst_cnt_d = '0;
        end
      end

      S_RST_HOLD: begin
        core_rst_o = 1'b1;
        core_ce_o  = 1'b1;
        rst_cnt_d  = rst_cnt_q + 1'b1;
        if (rst_cnt_q == RST_LAST) begin
          state_d       = S_RUN;
          rst_cnt_d     = '0;
          cycle_count_d = '0;
          bp_hit_d      = 1'b0;
          timeout_d     = 1'b0;
          skip_bp_d     = 1'b0;
        end
      end

      S_RUN: begin
        // The core is frozen in the stopping cycle, so a breakpoint leaves
        // the instruction at bp_addr unexecuted.
        core_ce_o = !stop_now;
        skip_bp_d = 1'b0;
        if (limit_hit) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else if (bp_match) begin
          state_d  = S_HALTED;
          bp_hit_d = 1'b1;
        end else if (halt_req_i) begin
          state_d  = S_HALTED;
          bp_hit_d = 1'b0;
        end else begin
          cycle_count_d = cnt_inc;
        end
      end

      S_STEP: begin
        core_ce_o     = 1'b1;
        cycle_count_d = cnt_inc;
        skip_bp_d     = 1'b1;
        state_d       = S_HALTED;
      end

      S_HALTED: begin
        if (start_i) begin
          state_d   = S_RST_HOLD;
          rst_cnt_d = '0;
        end else if (step_i) begin
          state_d = S_STEP;
        end else if (halt_fall) begin
          state_d   = S_RUN;
          skip_bp_d = 1'b1;
        end
      end

      S_DONE: begin
        done_o = 1'b1;
        if (start_i) begin
          state_d   = S_RST_HOLD;
          rst_cnt_d = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign state_o       = state_q;
  assign cycle_count_o = cycle_count_q;
  assign bp_hit_o      = bp_hit_q;
  assign timeout_o     = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_run_ctrl.sv
//==============================================================================
// Module      : tb_mips_run_ctrl
// Description : Self-checking bench for mips_run_ctrl. A small core model
//               advances the PC by 4 on every enabled, non-reset cycle.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mips_run_ctrl;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_HOLD = 3'd1, ST_RUN = 3'd2,
                         ST_STEP = 3'd3, ST_HALT = 3'd4, ST_DONE = 3'd5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, step = 1'b0, halt_req = 1'b0, bp_en = 1'b0;
  logic [31:0] bp_addr = 32'h0;
  logic [15:0] cycle_limit = 16'd0;
  logic [31:0] pc = 32'h0;
  logic        core_rst, core_ce, bp_hit, timeout, done;
  logic [2:0]  state;
  logic [15:0] cycle_count;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mips_run_ctrl #(.RST_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start_i(start), .step_i(step), .halt_req_i(halt_req),
    .bp_en_i(bp_en), .bp_addr_i(bp_addr), .cycle_limit_i(cycle_limit),
    .pc_current_i(pc), .core_rst_o(core_rst), .core_ce_o(core_ce),
    .state_o(state), .cycle_count_o(cycle_count), .bp_hit_o(bp_hit),
    .timeout_o(timeout), .done_o(done)
  );

  // Core model: PC resets to 0 and advances one instruction per enabled cycle.
  always @(posedge clk) begin
    if (core_rst)     pc <= 32'h0;
    else if (core_ce) pc <= pc + 32'd4;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait until the DUT reaches state s, counting RST_HOLD cycles and enabled
  // RUN cycles on the way. Inputs are held constant while waiting.
  task automatic wait_state(input logic [2:0] s, input int max_cyc, input string name,
                            output int ce_cnt, output int hold_cnt);
    int n;
    n = 0; ce_cnt = 0; hold_cnt = 0;
    #1;
    while (state != s && n < max_cyc) begin
      if (state == ST_RUN && core_ce) ce_cnt++;
      if (state == ST_HOLD) hold_cnt++;
      @(posedge clk);
      #1;
      n++;
    end
    if (state != s) begin
      n_fail++;
      n_chk++;
      $display("FAIL %s: wait expired in state %0d, expected state %0d", name, state, s);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  typedef struct {
    logic        rst, start, step, hreq;
    logic [2:0]  st;
    logic        ce, crst, dn, to;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [17];

  initial begin
    int ce_cnt, hold_cnt, n;

    // Table: limit of 3 core cycles, then restart and a halt/resume by level.
    tbl[0]  = '{1'b1,1'b0,1'b0,1'b0, ST_IDLE, 1'b0,1'b1,1'b0,1'b0, 16'd0};
    tbl[1]  = '{1'b1,1'b1,1'b0,1'b0, ST_IDLE, 1'b0,1'b1,1'b0,1'b0, 16'd0};
    tbl[2]  = '{1'b1,1'b0,1'b0,1'b0, ST_HOLD, 1'b1,1'b1,1'b0,1'b0, 16'd0};
    tbl[3]  = '{1'b1,1'b0,1'b0,1'b0, ST_HOLD, 1'b1,1'b1,1'b0,1'b0, 16'd0};
    tbl[4]  = '{1'b1,1'b0,1'b0,1'b0, ST_RUN,  1'b1,1'b0,1'b0,1'b0, 16'd0};
    tbl[5]  = '{1'b1,1'b1,1'b0,1'b0, ST_RUN,  1'b1,1'b0,1'b0,1'b0, 16'd1};
    tbl[6]  = '{1'b1,1'b0,1'b0,1'b0, ST_RUN,  1'b1,1'b0,1'b0,1'b0, 16'd2};
    tbl[7]  = '{1'b1,1'b0,1'b0,1'b0, ST_RUN,  1'b0,1'b0,1'b0,1'b0, 16'd3};
    tbl[8]  = '{1'b1,1'b0,1'b0,1'b0, ST_DONE, 1'b0,1'b0,1'b1,1'b1, 16'd3};
    tbl[9]  = '{1'b1,1'b0,1'b1,1'b1, ST_DONE, 1'b0,1'b0,1'b1,1'b1, 16'd3};
    tbl[10] = '{1'b1,1'b1,1'b0,1'b0, ST_DONE, 1'b0,1'b0,1'b1,1'b1, 16'd3};
    tbl[11] = '{1'b1,1'b0,1'b0,1'b0, ST_HOLD, 1'b1,1'b1,1'b0,1'b1, 16'd3};
    tbl[12] = '{1'b1,1'b0,1'b0,1'b1, ST_HOLD, 1'b1,1'b1,1'b0,1'b1, 16'd3};
    tbl[13] = '{1'b1,1'b0,1'b0,1'b1, ST_RUN,  1'b0,1'b0,1'b0,1'b0, 16'd0};
    tbl[14] = '{1'b1,1'b0,1'b0,1'b1, ST_HALT, 1'b0,1'b0,1'b0,1'b0, 16'd0};
    tbl[15] = '{1'b1,1'b0,1'b0,1'b0, ST_HALT, 1'b0,1'b0,1'b0,1'b0, 16'd0};
    tbl[16] = '{1'b1,1'b0,1'b0,1'b0, ST_RUN,  1'b1,1'b0,1'b0,1'b0, 16'd0};

    cycle_limit = 16'd3;
    rst = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 17; i++) begin
      rst = tbl[i].rst; start = tbl[i].start; step = tbl[i].step; halt_req = tbl[i].hreq;
      #1;
      chk($sformatf("tbl[%0d].state", i), 64'(state), 64'(tbl[i].st));
      chk($sformatf("tbl[%0d].core_ce", i), 64'(core_ce), 64'(tbl[i].ce));
      chk($sformatf("tbl[%0d].core_rst", i), 64'(core_rst), 64'(tbl[i].crst));
      chk($sformatf("tbl[%0d].done", i), 64'(done), 64'(tbl[i].dn));
      chk($sformatf("tbl[%0d].timeout", i), 64'(timeout), 64'(tbl[i].to));
      chk($sformatf("tbl[%0d].cycle_count", i), 64'(cycle_count), 64'(tbl[i].cnt));
      chk($sformatf("tbl[%0d].bp_hit", i), 64'(bp_hit), 64'd0);
      tick();
    end
    start = 1'b0; step = 1'b0; halt_req = 1'b0;

    // Test 1: budget of 50 core cycles.
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    chk("t1.reset_state", 64'(state), 64'(ST_IDLE));
    bp_en = 1'b0; cycle_limit = 16'd50;
    pulse_start();
    wait_state(ST_DONE, 200, "t1.wait_done", ce_cnt, hold_cnt);
    chk("t1.rst_hold_cycles", 64'(hold_cnt), 64'd2);
    chk("t1.run_ce_cycles", 64'(ce_cnt), 64'd50);
    chk("t1.timeout", 64'(timeout), 64'd1);
    chk("t1.cycle_count", 64'(cycle_count), 64'd50);
    chk("t1.done", 64'(done), 64'd1);
    chk("t1.pc", 64'(pc), 64'hC8);

    // Test 2: breakpoint at 0x5C, unlimited budget.
    bp_en = 1'b1; bp_addr = 32'h5C; cycle_limit = 16'd0;
    pulse_start();
    wait_state(ST_HALT, 200, "t2.wait_halt", ce_cnt, hold_cnt);
    chk("t2.pc", 64'(pc), 64'h5C);
    chk("t2.bp_hit", 64'(bp_hit), 64'd1);
    chk("t2.cycle_count", 64'(cycle_count), 64'd23);
    chk("t2.core_ce", 64'(core_ce), 64'd0);
    chk("t2.timeout_cleared", 64'(timeout), 64'd0);
    tick();
    chk("t2.stays_halted", 64'(state), 64'(ST_HALT));
    chk("t2.pc_frozen", 64'(pc), 64'h5C);

    // Test 3: two single steps.
    for (int k = 0; k < 2; k++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      #1;
      chk($sformatf("t3.step%0d.state", k), 64'(state), 64'(ST_STEP));
      chk($sformatf("t3.step%0d.core_ce", k), 64'(core_ce), 64'd1);
      tick();
      chk($sformatf("t3.step%0d.halted", k), 64'(state), 64'(ST_HALT));
      chk($sformatf("t3.step%0d.pc", k), 64'(pc), 64'h60 + 64'(4 * k));
      chk($sformatf("t3.step%0d.cycle_count", k), 64'(cycle_count), 64'(24 + k));
    end
    repeat (2) tick();
    chk("t3.pc_hold", 64'(pc), 64'h64);

    // Test 4: rerun to the breakpoint, then resume by a halt_req pulse.
    pulse_start();
    wait_state(ST_HALT, 200, "t4.wait_halt", ce_cnt, hold_cnt);
    chk("t4.pc_at_bp", 64'(pc), 64'h5C);
    halt_req = 1'b1;
    tick();
    chk("t4.halted_while_req", 64'(state), 64'(ST_HALT));
    halt_req = 1'b0;
    tick();
    chk("t4.resumed", 64'(state), 64'(ST_RUN));
    chk("t4.resume_ce", 64'(core_ce), 64'd1);
    tick();
    chk("t4.no_retrigger", 64'(state), 64'(ST_RUN));
    chk("t4.pc_advanced", 64'(pc), 64'h60);
    chk("t4.bp_hit_kept", 64'(bp_hit), 64'd1);
    repeat (3) tick();

    // Test 6: reset mid-RUN with sticky flag and counter non-zero.
    chk("t6.pre_state", 64'(state), 64'(ST_RUN));
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("t6.state", 64'(state), 64'(ST_IDLE));
    chk("t6.core_rst", 64'(core_rst), 64'd1);
    chk("t6.core_ce", 64'(core_ce), 64'd0);
    chk("t6.cycle_count", 64'(cycle_count), 64'd0);
    chk("t6.bp_hit", 64'(bp_hit), 64'd0);
    chk("t6.timeout", 64'(timeout), 64'd0);

    // Test 5: halt_req with start in RUN, then start with step in HALTED.
    bp_en = 1'b0;
    pulse_start();
    wait_state(ST_RUN, 20, "t5.wait_run", ce_cnt, hold_cnt);
    n = 0;
    while (cycle_count != 16'd10 && n < 50) begin
      tick();
      n++;
    end
    chk("t5.reached_10", 64'(cycle_count), 64'd10);
    halt_req = 1'b1; start = 1'b1;
    #1;
    chk("t5.stop_ce", 64'(core_ce), 64'd0);
    tick();
    start = 1'b0;
    chk("t5.state_halted", 64'(state), 64'(ST_HALT));
    chk("t5.bp_hit", 64'(bp_hit), 64'd0);
    chk("t5.cycle_count", 64'(cycle_count), 64'd10);
    start = 1'b1; step = 1'b1;
    tick();
    start = 1'b0; step = 1'b0; halt_req = 1'b0;
    chk("t5.start_wins", 64'(state), 64'(ST_HOLD));
    chk("t5.core_rst", 64'(core_rst), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
